chacha20_keystream_xor: RTL
===========================

Name: chacha20_keystream_xor

Overview:
- Drives the ChaCha20 block-function core (PerformQround) and consumes what it produces.
- Builds the 4x4 initial state from key, nonce and block counter, and pulses the core's setRounds.
- Captures each finished 16-word keystream block and XORs it word-by-word onto a valid/ready plaintext stream to give ciphertext (or plaintext on decrypt).
- Sits between the AEAD control/datapath and the block-function core; it is the core's only initiator and consumer.

Parameters:
- LEN_W, 16, width of the message-length field in 32-bit words (max message 2^LEN_W-1 words).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches key/nonce/ctr_init/len_words; ignored unless idle
- key  in  256  key words 0..7, word0 = key[31:0]
- nonce  in  96  nonce words 0..2, word0 = nonce[31:0]
- ctr_init  in  32  initial block counter
- len_words  in  LEN_W  message length in 32-bit words; 0 = no-op
- busy  out  1  high from start-accept until last output word is accepted
- done  out  1  one-cycle pulse after last output word handshake
- ctr_wrap  out  1  sticky; set when the block counter wraps 0xFFFFFFFF->0; cleared on start
- din  in  32  plaintext word (little-endian packed)
- din_valid  in  1  input handshake
- din_ready  out  1  input handshake
- dout  out  32  din XOR keystream word
- dout_valid  out  1  output handshake
- dout_ready  in  1  output handshake
- core_matrix  out  32x4x4  initial state to core, [row][col]
- core_setrounds  out  1  core init strobe
- core_block  in  32x4x4  finished block from core
- core_blockready  in  1  core block-valid level

Behaviour:
- Reset state (async, rst_n low): state IDLE; all outputs 0; core_matrix all 0; counter, word index and remaining count 0.
- Matrix layout, combinational from registers:
  - row0 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574
  - row1 = key w0..w3; row2 = key w4..w7
  - row3 = ctr, nonce w0, w1, w2
- core_matrix is held stable for the whole time a block is in flight.

FSM:
- IDLE: start with len_words!=0 -> latch inputs, ctr=ctr_init, rem=len_words, clear ctr_wrap -> INIT.
  - start with len_words==0 -> done pulse the next cycle, stay IDLE.
  - start while not IDLE is ignored.
- INIT: core_setrounds=1 for exactly 1 cycle -> WAIT.
- WAIT: on the first cycle core_blockready=1, capture core_block into a 16x32 buffer, idx=0 -> STREAM.
- STREAM: din_ready = !dout_valid | dout_ready (single output register).
  - On din handshake: dout <= din ^ buf[idx], dout_valid<=1, idx++, rem--.
  - Keystream word order: word i = block[i/4][i%4].
  - dout_valid drops on dout_ready when no new word is loaded.
  - When idx reaches 16 and rem!=0: ctr++ (wrap sets ctr_wrap) -> INIT.
  - When rem reaches 0 -> DRAIN.
  - din_ready is 0 outside STREAM.
- DRAIN: wait for the final dout handshake -> done pulse, IDLE.

Latency and boundaries:
- Block latency is set by the core; this block adds 1 cycle (INIT) plus 1 capture cycle.
- A partial final block discards the unused keystream words.
- Exactly 16 words: no second block is requested.
- Stalls: din_valid low or dout_ready low freeze idx, rem and dout; dout stays stable while valid and not ready.
- Counter wraps modulo 2^32; ctr_wrap is reported but streaming continues.
- rst_n low mid-operation aborts immediately to reset values; a partially streamed message is lost.
- core_blockready held high across cycles is captured once per request (only in WAIT).

Decomposition:
- Shared package chacha_pkg:
  - word_t (32-bit), state_t (word_t [3:0][3:0])
  - the four sigma constants
  - state-enum typedef {IDLE, INIT, WAIT, STREAM, DRAIN}
- Optional sub-module chacha_state_builder: combinational key/nonce/ctr -> state_t.
- Top holds the FSM, keystream buffer and stream register.

Test Plan:
- Stub core returns word[r][c] = 0x10000000+4r+c, 4 cycles after setrounds. Start with len_words=3, din 0,1,2 -> dout 0x10000000, 0x10000000, 0x10000000 (word i XOR i, i=0..2). One setrounds, done pulse, busy low.
- Same stub, len_words=20 -> two setrounds pulses. Second core_matrix[3][0] = ctr_init+1. Words 16..19 use buffer words 0..3. Exactly 20 dout words.
- Real core, RFC 8439 2.4.2 key 00..1f, nonce 000000000000004a00000000, ctr 1, din0 = 0x6964614c ("Ladi") -> dout0 = 0x9a352e6e.
- ctr_init=0xFFFFFFFF, len_words=17 -> second block uses ctr 0, ctr_wrap=1 stays high until next start.
- Random dout_ready/din_valid backpressure over 40 words -> no lost or duplicated words, dout stable while stalled, matches model.
- rst_n asserted during STREAM word 5 -> all outputs 0 asynchronously. A following start behaves as fresh; len_words=0 start -> done next cycle, no setrounds.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 keystream front-end.
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] state_t;

    // "expand 32-byte k" as four little-endian words
    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT,
        STREAM,
        DRAIN
    } fsm_t;

endpackage

// File: rtl/chacha_state_builder.sv
// Combinational assembly of the 4x4 ChaCha20 initial state, indexed [row][col].
module chacha_state_builder
    import chacha_pkg::*;
(
    input  logic [255:0]          key_i,
    input  logic [95:0]           nonce_i,
    input  logic [31:0]           ctr_i,
    output logic [3:0][3:0][31:0] state_o
);

    always_comb begin
        state_o[0][0] = SIGMA0;
        state_o[0][1] = SIGMA1;
        state_o[0][2] = SIGMA2;
        state_o[0][3] = SIGMA3;
        state_o[1]    = key_i[127:0];
        state_o[2]    = key_i[255:128];
        // column 0 is the block counter, columns 1..3 the nonce words
        state_o[3]    = {nonce_i, ctr_i};
    end

endmodule

// File: rtl/chacha20_keystream_xor.sv
// Requests ChaCha20 blocks from the core and XORs the keystream onto a word stream.
module chacha20_keystream_xor
    import chacha_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [255:0]          key,
    input  logic [95:0]           nonce,
    input  logic [31:0]           ctr_init,
    input  logic [LEN_W-1:0]      len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  ctr_wrap,
    input  logic [31:0]           din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [31:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [3:0][3:0][31:0] core_matrix,
    output logic                  core_setrounds,
    input  logic [3:0][3:0][31:0] core_block,
    input  logic                  core_blockready
);

    fsm_t             state_q, state_d;
    logic [255:0]     key_q;
    logic [95:0]      nonce_q;
    word_t            ctr_q;
    logic [LEN_W-1:0] rem_q;
    logic [3:0]       idx_q;
    state_t           buf_q;
    word_t            dout_q;
    logic             dout_valid_q, done_q, ctr_wrap_q;
    state_t           built;

    logic start_acc, capture, in_hs, out_hs, last_word, block_end;

    assign start_acc = start && (state_q == IDLE);
    assign capture   = (state_q == WAIT) && core_blockready;
    assign in_hs     = din_valid && din_ready;
    assign out_hs    = dout_valid_q && dout_ready;
    assign last_word = (rem_q == LEN_W'(1));
    assign block_end = (idx_q == 4'd15);

    chacha_state_builder u_builder (
        .key_i   (key_q),
        .nonce_i (nonce_q),
        .ctr_i   (ctr_q),
        .state_o (built)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start && (len_words != '0)) state_d = INIT;
            INIT:   state_d = WAIT;
            WAIT:   if (core_blockready) state_d = STREAM;
            STREAM: begin
                if (in_hs) begin
                    if (last_word)      state_d = DRAIN;
                    else if (block_end) state_d = INIT;
                end
            end
            DRAIN:  if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != IDLE);
        core_setrounds = (state_q == INIT);
        din_ready      = (state_q == STREAM) && (!dout_valid_q || dout_ready);
        // zero while idle, otherwise steady from latched registers for the whole request
        core_matrix    = (state_q == IDLE) ? '0 : built;
        dout           = dout_q;
        dout_valid     = dout_valid_q;
        done           = done_q;
        ctr_wrap       = ctr_wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q        <= '0;
            rem_q        <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            ctr_wrap_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc) begin
                ctr_wrap_q <= 1'b0;
                if (len_words == '0) begin
                    done_q <= 1'b1;
                end else begin
                    ctr_q <= ctr_init;
                    rem_q <= len_words;
                end
            end
            if (capture) idx_q <= '0;
            if (in_hs) begin
                dout_q       <= din ^ buf_q[idx_q[3:2]][idx_q[1:0]];
                dout_valid_q <= 1'b1;
                idx_q        <= idx_q + 4'd1;
                rem_q        <= rem_q - LEN_W'(1);
                if (block_end && !last_word) begin
                    ctr_q <= ctr_q + 32'd1;
                    if (ctr_q == 32'hFFFF_FFFF) ctr_wrap_q <= 1'b1;
                end
            end else if (out_hs) begin
                dout_valid_q <= 1'b0;
            end
            if ((state_q == DRAIN) && out_hs) done_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start_acc) begin
            key_q   <= key;
            nonce_q <= nonce;
        end
        if (capture) buf_q <= core_block;
    end

endmodule
